// File: rtl/spi_byte_master_if.sv
// Byte-stream handshake between a byte producer/consumer and the SPI byte master.
// tx side is valid/ready; rx side is a one-cycle pulse with no backpressure.
interface spi_byte_master_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output tx_valid, tx_data, tx_last, input tx_ready, rx_valid, rx_data);
  modport slave  (input tx_valid, tx_data, tx_last, output tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 initiator: sends one byte per accepted tx beat MSB first and returns the byte
// shifted in from MISO; tx_last closes the chip-select frame after that byte.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  spi_byte_master_if.slave  bus,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_ss_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [7:0] HC_LOAD = 8'(CLK_DIV - 1);

  state_t     state_r;
  logic [7:0] hc_r;
  logic [7:0] tx_sh_r;
  logic [7:0] rx_sh_r;
  logic [2:0] bit_cnt_r;
  logic       last_r;
  logic       tx_ready_r;
  logic       rx_valid_r;
  logic [7:0] rx_data_r;
  logic       busy_r;
  logic       sck_r;
  logic       ss_n_r;
  logic       mosi_r;
  logic       hc_zero_s;
  logic       accept_s;

  assign hc_zero_s    = (hc_r == 8'd0);
  assign accept_s     = bus.tx_valid && tx_ready_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_data  = rx_data_r;
  assign busy         = busy_r;
  assign spi_sck      = sck_r;
  assign spi_ss_n     = ss_n_r;
  assign spi_mosi     = mosi_r;

  // Frame sequencer: half-period counter, SCK phase, shift registers and all registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r    <= IDLE;
      hc_r       <= 8'd0;
      tx_sh_r    <= 8'd0;
      rx_sh_r    <= 8'd0;
      bit_cnt_r  <= 3'd0;
      last_r     <= 1'b0;
      tx_ready_r <= 1'b1;
      rx_valid_r <= 1'b0;
      rx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      sck_r      <= 1'b0;
      ss_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        IDLE, WAIT: begin
          // WAIT reuses the accept path so SS stays low between bytes of a frame
          if (accept_s) begin
            tx_sh_r    <= bus.tx_data;
            last_r     <= bus.tx_last;
            bit_cnt_r  <= 3'd0;
            hc_r       <= HC_LOAD;
            ss_n_r     <= 1'b0;
            mosi_r     <= bus.tx_data[7];
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= SETUP;
          end else begin
            hc_r <= HC_LOAD;
          end
        end
        SETUP: begin
          if (hc_zero_s) begin
            sck_r   <= 1'b1;
            rx_sh_r <= {rx_sh_r[6:0], spi_miso};
            hc_r    <= HC_LOAD;
            state_r <= SHIFT;
          end else begin
            hc_r <= hc_r - 8'd1;
          end
        end
        SHIFT: begin
          if (!hc_zero_s) begin
            hc_r <= hc_r - 8'd1;
          end else if (!sck_r) begin
            sck_r   <= 1'b1;
            rx_sh_r <= {rx_sh_r[6:0], spi_miso};
            hc_r    <= HC_LOAD;
          end else begin
            sck_r <= 1'b0;
            hc_r  <= HC_LOAD;
            // falling edge after the eighth rise completes the byte; MOSI keeps its last bit
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r  <= 3'd0;
              rx_data_r  <= rx_sh_r;
              rx_valid_r <= 1'b1;
              if (last_r) begin
                state_r <= HOLD;
              end else begin
                tx_ready_r <= 1'b1;
                state_r    <= WAIT;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              tx_sh_r   <= {tx_sh_r[6:0], 1'b0};
              mosi_r    <= tx_sh_r[6];
            end
          end
        end
        HOLD: begin
          if (hc_zero_s) begin
            ss_n_r  <= 1'b1;
            mosi_r  <= 1'b0;
            hc_r    <= HC_LOAD;
            state_r <= GAP;
          end else begin
            hc_r <= hc_r - 8'd1;
          end
        end
        GAP: begin
          if (hc_zero_s) begin
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            hc_r <= hc_r - 8'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          tx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          sck_r      <= 1'b0;
          ss_n_r     <= 1'b1;
          mosi_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: CLK_DIV=4 against an EEPROM-like slave, CLK_DIV=1 with MISO tied low.
module tb_spi_byte_master;
  localparam logic [7:0] EE_SR = 8'h82;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  spi_byte_master_if b4();
  spi_byte_master_if b1();
  logic busy4, sck4, ss4, mosi4;
  logic miso4 = 1'b0;
  logic busy1, sck1, ss1, mosi1;
  logic miso1 = 1'b0;

  spi_byte_master #(.CLK_DIV(4)) dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(b4), .busy(busy4),
    .spi_sck(sck4), .spi_ss_n(ss4), .spi_mosi(mosi4), .spi_miso(miso4));
  spi_byte_master #(.CLK_DIV(1)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(b1), .busy(busy1),
    .spi_sck(sck1), .spi_ss_n(ss1), .spi_mosi(mosi1), .spi_miso(miso1));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] exp_rx4[$];
  logic [7:0] exp_rx1[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] resp_q[$];
  int rx_cnt4 = 0, rx_cyc4 = 0, rx_cnt1 = 0, rx_cyc1 = 0;
  int rise_cnt4 = 0, last_rise4 = 0, last_fall4 = 0, ss_rise4 = 0, ss_rise_cnt4 = 0;
  int last_rise1 = -1;
  logic prev_sck4 = 1'b0, prev_ss4 = 1'b1, prev_sck1 = 1'b0, prev_ss1 = 1'b1;
  logic sl_ss_prev = 1'b1, sl_sck_prev = 1'b0;
  logic [7:0] sl_out = 8'hFF, sl_in = 8'h00;
  int sl_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge PCLK) cyc++;

  // EEPROM-like mode-0 slave: shifts MOSI in on SCK rise, presents the next MISO bit on SCK fall
  always @(ss4 or sck4) begin
    if (sl_ss_prev && !ss4) begin
      sl_cnt = 0;
      if (resp_q.size() > 0) sl_out = resp_q.pop_front();
      else sl_out = 8'hFF;
      miso4 = sl_out[7];
    end else if (!ss4 && !sl_sck_prev && sck4) begin
      sl_in = {sl_in[6:0], mosi4};
      sl_cnt++;
    end else if (!ss4 && sl_sck_prev && !sck4) begin
      if (sl_cnt == 8) begin
        sl_cnt = 0;
        if (exp_mosi.size() > 0) chk("mosi_byte", {24'd0, sl_in}, {24'd0, exp_mosi.pop_front()});
        else chk("mosi_unexpected", 32'd1, 32'd0);
        if (sl_in == 8'h05) sl_out = EE_SR;
        else if (resp_q.size() > 0) sl_out = resp_q.pop_front();
        else sl_out = 8'hFF;
      end else begin
        sl_out = {sl_out[6:0], 1'b0};
      end
      miso4 = sl_out[7];
    end
    sl_ss_prev  = ss4;
    sl_sck_prev = sck4;
  end

  // Output monitors: rx scoreboards, SCK timing and SS edge timestamps
  always @(negedge PCLK) begin
    if (b4.rx_valid === 1'b1) begin
      rx_cnt4++;
      rx_cyc4 = cyc;
      if (exp_rx4.size() > 0) chk("rx4_data", {24'd0, b4.rx_data}, {24'd0, exp_rx4.pop_front()});
      else chk("rx4_unexpected", 32'd1, 32'd0);
    end
    if (b1.rx_valid === 1'b1) begin
      rx_cnt1++;
      rx_cyc1 = cyc;
      if (exp_rx1.size() > 0) chk("rx1_data", {24'd0, b1.rx_data}, {24'd0, exp_rx1.pop_front()});
      else chk("rx1_unexpected", 32'd1, 32'd0);
    end
    if (!prev_sck4 && sck4) begin
      rise_cnt4++;
      last_rise4 = cyc;
    end
    if (prev_sck4 && !sck4 && PRESETn) begin
      chk("sck4_high_time", cyc - last_rise4, 32'd4);
      last_fall4 = cyc;
    end
    if (!prev_ss4 && ss4) begin
      ss_rise4 = cyc;
      ss_rise_cnt4++;
    end
    if (prev_ss1 && !ss1) last_rise1 = -1;
    if (!prev_sck1 && sck1) begin
      if (last_rise1 >= 0) chk("sck1_period", cyc - last_rise1, 32'd2);
      last_rise1 = cyc;
    end
    prev_sck4 = sck4;
    prev_ss4  = ss4;
    prev_sck1 = sck1;
    prev_ss1  = ss1;
  end

  task automatic send4(input logic [7:0] d, input logic l, input logic track);
    int n;
    @(negedge PCLK);
    b4.tx_valid = 1'b1;
    b4.tx_data  = d;
    b4.tx_last  = l;
    n = 0;
    while (b4.tx_ready !== 1'b1 && n < 400) begin
      @(negedge PCLK);
      n++;
    end
    chk("tx4_ready_wait", {31'd0, b4.tx_ready}, 32'd1);
    if (track) exp_mosi.push_back(d);
    @(posedge PCLK);
    #1 acc_cyc = cyc;
    @(negedge PCLK);
    b4.tx_valid = 1'b0;
  endtask

  task automatic wait_idle4();
    int n;
    n = 0;
    while (!(busy4 === 1'b0 && b4.tx_ready === 1'b1) && n < 1000) begin
      @(negedge PCLK);
      n++;
    end
    chk("idle4_wait", {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    int n, r, acc1;
    logic bad;
    b4.tx_valid = 1'b0; b4.tx_data = 8'h00; b4.tx_last = 1'b0;
    b1.tx_valid = 1'b0; b1.tx_data = 8'h00; b1.tx_last = 1'b0;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_ss_n", {31'd0, ss4}, 32'd1);
    chk("rst_sck", {31'd0, sck4}, 32'd0);
    chk("rst_mosi", {31'd0, mosi4}, 32'd0);
    chk("rst_tx_ready", {31'd0, b4.tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_rx_valid", {31'd0, b4.rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, b4.rx_data}, 32'd0);
    chk("rst_ss_n_div1", {31'd0, ss1}, 32'd1);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("rst_no_rx", rx_cnt4, 32'd0);

    // single byte A5 with last, slave answers 3C
    resp_q.push_back(8'h3C);
    exp_rx4.push_back(8'h3C);
    r = rise_cnt4;
    send4(8'hA5, 1'b1, 1'b1);
    wait_idle4();
    chk("a5_latency", rx_cyc4 - acc_cyc + 1, 32'd65);
    chk("a5_rises", rise_cnt4 - r, 32'd8);
    chk("a5_ss_hold", ss_rise4 - last_fall4, 32'd4);
    chk("a5_rx_held", {24'd0, b4.rx_data}, 32'h3C);

    // EEPROM RDSR: 05 then 00 in one frame, second byte returns the status register
    n = ss_rise_cnt4;
    exp_rx4.push_back(8'hFF);
    exp_rx4.push_back(EE_SR);
    send4(8'h05, 1'b0, 1'b1);
    send4(8'h00, 1'b1, 1'b1);
    wait_idle4();
    chk("rdsr_one_frame", ss_rise_cnt4 - n, 32'd1);
    chk("rdsr_status", {24'd0, b4.rx_data}, {24'd0, EE_SR});

    // stall of twenty cycles between bytes of one frame
    resp_q.push_back(8'hC3);
    resp_q.push_back(8'h69);
    exp_rx4.push_back(8'hC3);
    exp_rx4.push_back(8'h69);
    n = rx_cnt4;
    send4(8'h11, 1'b0, 1'b1);
    r = 0;
    while (rx_cnt4 == n && r < 300) begin
      @(negedge PCLK);
      r++;
    end
    chk("stall_first_rx", rx_cnt4 - n, 32'd1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge PCLK);
      if (sck4 !== 1'b0 || ss4 !== 1'b0) bad = 1'b1;
    end
    chk("stall_lines", {31'd0, bad}, 32'd0);
    chk("stall_ready", {31'd0, b4.tx_ready}, 32'd1);
    send4(8'hE7, 1'b1, 1'b1);
    wait_idle4();

    // asynchronous reset after the third SCK rise
    resp_q.push_back(8'hAB);
    n = rx_cnt4;
    r = rise_cnt4;
    send4(8'h5A, 1'b1, 1'b0);
    acc1 = 0;
    while (rise_cnt4 - r < 3 && acc1 < 300) begin
      @(negedge PCLK);
      acc1++;
    end
    chk("midrst_third_rise", rise_cnt4 - r, 32'd3);
    PRESETn = 1'b0;
    #1;
    chk("midrst_ss_n", {31'd0, ss4}, 32'd1);
    chk("midrst_sck", {31'd0, sck4}, 32'd0);
    chk("midrst_busy", {31'd0, busy4}, 32'd0);
    repeat (4) @(negedge PCLK);
    chk("midrst_no_rx", rx_cnt4 - n, 32'd0);
    PRESETn = 1'b1;
    resp_q.delete();
    resp_q.push_back(8'h4D);
    exp_rx4.push_back(8'h4D);
    send4(8'hB2, 1'b1, 1'b1);
    wait_idle4();

    // CLK_DIV=1 instance: FF with last, MISO tied low
    exp_rx1.push_back(8'h00);
    @(negedge PCLK);
    b1.tx_valid = 1'b1;
    b1.tx_data  = 8'hFF;
    b1.tx_last  = 1'b1;
    chk("div1_ready", {31'd0, b1.tx_ready}, 32'd1);
    @(posedge PCLK);
    #1 acc1 = cyc;
    @(negedge PCLK);
    b1.tx_valid = 1'b0;
    n = 0;
    while (!(busy1 === 1'b0 && b1.tx_ready === 1'b1) && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    chk("div1_idle", {31'd0, busy1}, 32'd0);
    chk("div1_rx_count", rx_cnt1, 32'd1);
    chk("div1_latency", rx_cyc1 - acc1 + 1, 32'd17);

    chk("rx4_queue_empty", exp_rx4.size(), 32'd0);
    chk("mosi_queue_empty", exp_mosi.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
